// File: rtl/arb_pkg.sv
// Shared types and constants for the 4:1 round-robin mux arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after last_grant, with wrap.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Offsets 1..4 from last_grant; offset 4 wraps back onto last_grant itself.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        any    = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin arbiter/sequencer for a 4:1 packet mux with a registered output beat.
// Grants are held until end-of-packet or MAX_BEATS accepted beats; grants are separated by one IDLE cycle.
module rr_mux_arbiter_4x1
    import arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   in_data,
    input  logic [NUM_REQ-1:0]         in_last,
    output logic [NUM_REQ-1:0]         in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [SEL_W-1:0]           sel,
    output logic                       busy
);

    localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] BEAT_CAP = CNT_W'(MAX_BEATS);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             slot_free;
    logic             accept;
    logic             release_now;
    logic [WIDTH-1:0] sel_data;

    rr_pick4 u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any        (any_req)
    );

    // Handshake: a beat moves on req[sel] && in_ready[sel]; the output slot is free
    // when empty or being drained this cycle, which allows 1 beat/cycle throughput.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_q == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
        end
        slot_free   = !out_valid_q || out_ready;
        accept      = (state_q == GRANT) && slot_free && req[sel_q];
        release_now = accept && (in_last[sel_q] || (beat_cnt_q + CNT_W'(1) == BEAT_CAP));
        in_ready    = '0;
        if (state_q == GRANT && slot_free) in_ready[sel_q] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = GRANT;
                    sel_d        = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (release_now) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = in_last[sel_q];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // last_grant resets to 3 so requester 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= SEL_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// Directed bench for rr_mux_arbiter_4x1 (MAX_BEATS=4): reset, single packet,
// round-robin order, backpressure, beat cap and mid-packet reset.
module tb_rr_mux_arbiter_4x1;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req = '0;
    logic [4*WIDTH-1:0] in_data = '0;
    logic [3:0]        in_last = '0;
    logic [3:0]        in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic [1:0]        sel;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    rr_mux_arbiter_4x1 #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int r, input logic [WIDTH-1:0] v);
        in_data[r*WIDTH +: WIDTH] = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req       = 4'($urandom_range(1, 15));
        in_data   = $urandom;
        in_last   = 4'($urandom_range(0, 15));
        out_ready = 1'($urandom_range(0, 1));
        #17;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%0b exp=0", out_last); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", sel); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        @(negedge clk);
        req = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        req = 4'b0100; out_ready = 1'b1; in_last = '0;
        set_data(2, 8'hA1);
        tick();
        checks++; if (sel !== 2'd2) begin failures++; $display("FAIL single_sel got=%0d exp=2", sel); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", busy); end
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_last !== 1'b0) begin
            failures++; $display("FAIL single_beat1 got=v%0b d%0h l%0b exp=v1 dA1 l0", out_valid, out_data, out_last); end
        set_data(2, 8'hA2);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_last !== 1'b0) begin
            failures++; $display("FAIL single_beat2 got=v%0b d%0h l%0b exp=v1 dA2 l0", out_valid, out_data, out_last); end
        set_data(2, 8'hA3); in_last = 4'b0100;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA3 || out_last !== 1'b1) begin
            failures++; $display("FAIL single_beat3 got=v%0b d%0h l%0b exp=v1 dA3 l1", out_valid, out_data, out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_release_busy got=%0b exp=0", busy); end
        req = '0; in_last = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        apply_reset();
        req = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
        for (int g = 0; g < 6; g++) begin
            exp_sel = 2'(g % 4);
            tick();
            checks++; if (sel !== exp_sel || busy !== 1'b1) begin
                failures++; $display("FAIL rr_grant%0d got=sel%0d busy%0b exp=sel%0d busy1", g, sel, busy, exp_sel); end
            tick();
            checks++; if (out_data !== 8'(8'h10 + exp_sel) || out_last !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL rr_beat%0d got=d%0h l%0b busy%0b exp=d%0h l1 busy0", g, out_data, out_last, busy, 8'(8'h10 + exp_sel)); end
        end
        req = '0; in_last = '0;
        tick();
    endtask

    task automatic test_backpressure();
        req = 4'b0001; in_last = '0; out_ready = 1'b1;
        set_data(0, 8'hB1);
        tick();
        checks++; if (sel !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL bp_grant got=sel%0d busy%0b exp=sel0 busy1", sel, busy); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1) begin failures++; $display("FAIL bp_beat1 got=v%0b d%0h exp=v1 dB1", out_valid, out_data); end
        out_ready = 1'b0; set_data(0, 8'hB2); in_last = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready%0d got=%b exp=0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_last !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_hold%0d got=v%0b d%0h l%0b busy%0b exp=v1 dB1 l0 busy1", c, out_valid, out_data, out_last, busy); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_last !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_beat2 got=v%0b d%0h l%0b busy%0b exp=v1 dB2 l1 busy0", out_valid, out_data, out_last, busy); end
        req = '0; in_last = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_beat_cap();
        int k;
        req = 4'b1010; in_last = 4'b1000; out_ready = 1'b1;
        set_data(1, 8'hC0); set_data(3, 8'hD0);
        k = 0;
        for (int round = 0; round < 3; round++) begin
            tick();
            checks++; if (sel !== 2'd1 || busy !== 1'b1) begin
                failures++; $display("FAIL cap_grant_r%0d got=sel%0d busy%0b exp=sel1 busy1", round, sel, busy); end
            for (int b = 0; b < 4 && k < 10; b++) begin
                tick();
                checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'hC0 + k) || out_last !== (k == 9)) begin
                    failures++; $display("FAIL cap_beat%0d got=v%0b d%0h l%0b exp=v1 d%0h l%0b", k, out_valid, out_data, out_last, 8'(8'hC0 + k), (k == 9)); end
                k++;
                set_data(1, 8'(8'hC0 + k));
                in_last[1] = (k == 9);
            end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cap_release_r%0d got=%0b exp=0", round, busy); end
            if (round == 0) begin
                tick();
                checks++; if (sel !== 2'd3 || busy !== 1'b1) begin failures++; $display("FAIL cap_grant3 got=sel%0d busy%0b exp=sel3 busy1", sel, busy); end
                tick();
                checks++; if (out_data !== 8'hD0 || out_last !== 1'b1 || busy !== 1'b0) begin
                    failures++; $display("FAIL cap_req3_beat got=d%0h l%0b busy%0b exp=dD0 l1 busy0", out_data, out_last, busy); end
                req = 4'b0010; in_last[3] = 1'b0;
            end
        end
        req = '0; in_last = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        req = 4'b0100; in_last = '0; out_ready = 1'b1;
        set_data(2, 8'hE0);
        tick();
        checks++; if (sel !== 2'd2) begin failures++; $display("FAIL rmid_grant got=%0d exp=2", sel); end
        tick();
        set_data(2, 8'hE1);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hE1) begin failures++; $display("FAIL rmid_beat2 got=v%0b d%0h exp=v1 dE1", out_valid, out_data); end
        set_data(2, 8'hE2);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            failures++; $display("FAIL rmid_out_clear got=v%0b d%0h l%0b exp=v0 d0 l0", out_valid, out_data, out_last); end
        checks++; if (sel !== 2'd0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
            failures++; $display("FAIL rmid_ctrl_clear got=sel%0d busy%0b rdy%b exp=sel0 busy0 rdy0000", sel, busy, in_ready); end
        req = 4'b0101; set_data(0, 8'h50);
        #1;
        rst = 1'b0;
        tick();
        checks++; if (sel !== 2'd0 || busy !== 1'b1 || in_ready !== 4'b0001) begin
            failures++; $display("FAIL rmid_first_grant got=sel%0d busy%0b rdy%b exp=sel0 busy1 rdy0001", sel, busy, in_ready); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_beat_cap();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
